// File: rtl/rvee_exec_if.sv
// Execute-to-memory stage payload. The execute stage drives the instruction
// fields and valid; the memory stage answers with ready.
interface rvee_exec_if #(
  parameter int XLEN = 32
);
  logic            valid;
  logic [XLEN-1:0] pc;
  logic            rd_we;
  logic [4:0]      rd;
  logic [XLEN-1:0] result;
  logic            mem_load;
  logic            mem_store;
  logic [XLEN-1:0] mem_data;
  logic [1:0]      mem_size;
  logic            mem_sext;
  logic            ready;

  modport mem_port (
    input  valid, pc, rd_we, rd, result, mem_load, mem_store,
           mem_data, mem_size, mem_sext,
    output ready
  );

  modport ex_port (
    output valid, pc, rd_we, rd, result, mem_load, mem_store,
           mem_data, mem_size, mem_sext,
    input  ready
  );
endinterface

// File: rtl/rvee_mem.sv
// rvee memory stage: retires ALU results, performs single-outstanding loads and
// stores on the data bus, aligns/extends load data and emits one registered
// writeback (or misalignment exception) per instruction.
//
// Handshake: an instruction on ex is consumed in the cycle where ex.valid and
// ex.ready are both high; ex.valid must stay high with a stable payload until
// then. The bus request is taken when dbus_req_valid and dbus_req_ready are
// both high at a rising edge; request fields stay stable while waiting.
module rvee_mem #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  rvee_exec_if.mem_port   ex,
  output logic            dbus_req_valid,
  input  logic            dbus_req_ready,
  output logic [XLEN-1:0] dbus_addr,
  output logic            dbus_we,
  output logic [XLEN-1:0] dbus_wdata,
  output logic [3:0]      dbus_be,
  input  logic            dbus_rsp_valid,
  input  logic [XLEN-1:0] dbus_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] wb_pc,
  output logic            exc_misaligned,
  output logic [XLEN-1:0] exc_pc,
  output logic [XLEN-1:0] exc_addr,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_rd_we;
  logic [4:0]      r_rd;
  logic            r_store;
  logic [1:0]      r_size;
  logic            r_sext;
  logic [1:0]      r_lo;

  logic            w_is_mem;
  logic            w_legal;
  logic            w_ready;
  logic [XLEN-1:0] w_wdata;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_load;

  assign w_is_mem    = ex.mem_load | ex.mem_store;
  assign o_dbg_state = r_state;
  // ready is suppressed during reset so nothing is consumed while held
  assign ex.ready    = rst & w_ready;

  // Access legality from size and low address bits
  always_comb begin
    w_legal = 1'b0;
    case (ex.mem_size)
      2'd0:    w_legal = 1'b1;
      2'd1:    w_legal = ~ex.result[0];
      2'd2:    w_legal = (ex.result[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Consume signal: immediate for ALU/rejected ops, at bus accept for stores,
  // at response for loads
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_IDLE:  w_ready = ex.valid & (~w_is_mem | ~w_legal);
      S_REQ:   w_ready = ex.valid & r_store & dbus_req_ready;
      S_RSP:   w_ready = ex.valid & dbus_rsp_valid;
      default: w_ready = 1'b0;
    endcase
  end

  // Store lane replication and byte enables from the incoming payload
  always_comb begin
    w_wdata = ex.mem_data;
    w_be    = 4'b1111;
    case (ex.mem_size)
      2'd0: begin
        w_wdata = {4{ex.mem_data[7:0]}};
        w_be    = 4'b0001 << ex.result[1:0];
      end
      2'd1: begin
        w_wdata = {2{ex.mem_data[15:0]}};
        w_be    = 4'b0011 << ex.result[1:0];
      end
      default: begin
        w_wdata = ex.mem_data;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Load alignment and sign/zero extension using the latched access shape
  always_comb begin
    w_shift = dbus_rdata >> {r_lo, 3'b000};
    w_load  = w_shift;
    case (r_size)
      2'd0:    w_load = r_sext ? {{24{w_shift[7]}}, w_shift[7:0]}
                               : {24'd0, w_shift[7:0]};
      2'd1:    w_load = r_sext ? {{16{w_shift[15]}}, w_shift[15:0]}
                               : {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  // Stage FSM with registered bus request, writeback and exception outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_pc           <= '0;
      r_rd_we        <= 1'b0;
      r_rd           <= '0;
      r_store        <= 1'b0;
      r_size         <= '0;
      r_sext         <= 1'b0;
      r_lo           <= '0;
      dbus_req_valid <= 1'b0;
      dbus_addr      <= '0;
      dbus_we        <= 1'b0;
      dbus_wdata     <= '0;
      dbus_be        <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_pc          <= '0;
      exc_misaligned <= 1'b0;
      exc_pc         <= '0;
      exc_addr       <= '0;
    end else begin
      wb_valid       <= 1'b0;
      exc_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex.valid) begin
            if (!w_is_mem) begin
              wb_valid <= ex.rd_we & (ex.rd != 5'd0);
              wb_rd    <= ex.rd;
              wb_data  <= ex.result;
              wb_pc    <= ex.pc;
            end else if (!w_legal) begin
              exc_misaligned <= 1'b1;
              exc_pc         <= ex.pc;
              exc_addr       <= ex.result;
            end else begin
              r_pc           <= ex.pc;
              r_rd_we        <= ex.rd_we;
              r_rd           <= ex.rd;
              r_store        <= ex.mem_store;
              r_size         <= ex.mem_size;
              r_sext         <= ex.mem_sext;
              r_lo           <= ex.result[1:0];
              dbus_req_valid <= 1'b1;
              dbus_addr      <= {ex.result[XLEN-1:2], 2'b00};
              dbus_we        <= ex.mem_store;
              dbus_wdata     <= w_wdata;
              dbus_be        <= w_be;
              r_state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dbus_req_ready) begin
            dbus_req_valid <= 1'b0;
            r_state        <= r_store ? S_IDLE : S_RSP;
          end
        end
        S_RSP: begin
          if (dbus_rsp_valid) begin
            wb_valid <= r_rd_we & (r_rd != 5'd0);
            wb_rd    <= r_rd;
            wb_data  <= w_load;
            wb_pc    <= r_pc;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvee_mem.sv
// Bench for rvee_mem: table of single-instruction vectors with a small bus
// responder, plus hand sequences for ALU streaming and reset during a load.
module tb_rvee_mem;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rvee_exec_if #(.XLEN(32)) ex_if ();

  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic [31:0] dbus_addr;
  logic        dbus_we;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_rsp_valid;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        exc_misaligned;
  logic [31:0] exc_pc;
  logic [31:0] exc_addr;
  logic [1:0]  dbg_state;

  rvee_mem #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex             (ex_if),
    .dbus_req_valid (dbus_req_valid),
    .dbus_req_ready (dbus_req_ready),
    .dbus_addr      (dbus_addr),
    .dbus_we        (dbus_we),
    .dbus_wdata     (dbus_wdata),
    .dbus_be        (dbus_be),
    .dbus_rsp_valid (dbus_rsp_valid),
    .dbus_rdata     (dbus_rdata),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_pc          (wb_pc),
    .exc_misaligned (exc_misaligned),
    .exc_pc         (exc_pc),
    .exc_addr       (exc_addr),
    .o_dbg_state    (dbg_state)
  );

  localparam logic [31:0] RD_WORD = 32'h80FF7F01;
  localparam logic [31:0] JUNK    = 32'hDEADBEEF;

  typedef struct {
    bit          ld;
    bit          st;
    bit [1:0]    size;
    bit          sext;
    bit [31:0]   addr;
    bit [31:0]   data;
    bit          rd_we;
    bit [4:0]    rd;
    bit [31:0]   rdata;
    int          req_wait;
    int          rsp_wait;
    int          e_rdy;
    bit          e_req;
    bit [31:0]   e_addr;
    bit [31:0]   e_wdata;
    bit [3:0]    e_be;
    bit          e_wb;
    bit [31:0]   e_wb_data;
    bit          e_exc;
  } vec_t;

  vec_t vecs[15];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_op(input vec_t v, input logic [31:0] pc);
    ex_if.valid     = 1'b1;
    ex_if.pc        = pc;
    ex_if.rd_we     = v.rd_we;
    ex_if.rd        = v.rd;
    ex_if.result    = v.addr;
    ex_if.mem_load  = v.ld;
    ex_if.mem_store = v.st;
    ex_if.mem_data  = v.data;
    ex_if.mem_size  = v.size;
    ex_if.mem_sext  = v.sext;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] pc;
    int          rdy_cyc;
    int          low_cnt;
    int          gap;
    bit          req_seen, stable, pend, done, rdy_now;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    pc       = 32'h100 + 32'(idx) * 32'd4;
    rdy_cyc  = -1;
    low_cnt  = 0;
    gap      = 0;
    req_seen = 0;
    stable   = 1;
    pend     = 0;
    done     = 0;
    c_addr   = '0;
    c_wdata  = '0;
    c_be     = '0;
    c_we     = 1'b0;
    @(posedge clk); #1;
    drive_op(v, pc);
    dbus_req_ready = (v.req_wait == 0);
    dbus_rsp_valid = 1'b0;
    dbus_rdata     = JUNK;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if (dbus_req_valid) begin
        if (!req_seen) begin
          req_seen = 1;
          c_addr = dbus_addr; c_wdata = dbus_wdata; c_be = dbus_be; c_we = dbus_we;
        end else if (dbus_addr !== c_addr || dbus_wdata !== c_wdata ||
                     dbus_be !== c_be || dbus_we !== c_we) begin
          stable = 0;
        end
        if (dbus_req_ready) begin
          if (!dbus_we) pend = 1;
        end else begin
          low_cnt++;
        end
      end
      rdy_now = ex_if.ready;
      if (rdy_now) rdy_cyc = c;
      @(posedge clk); #1;
      dbus_req_ready = (low_cnt >= v.req_wait);
      if (rdy_now) begin
        ex_if.valid    = 1'b0;
        dbus_rsp_valid = 1'b0;
        dbus_rdata     = JUNK;
        done           = 1;
      end else if (pend) begin
        if (gap == v.rsp_wait) begin
          dbus_rsp_valid = 1'b1;
          dbus_rdata     = v.rdata;
        end else begin
          gap++;
        end
      end
    end
    check($sformatf("v%0d_timeout", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_ready_cycle", idx), 32'(rdy_cyc), 32'(v.e_rdy));
    check($sformatf("v%0d_req_seen", idx), 32'(req_seen), 32'(v.e_req));
    if (v.e_req) begin
      check($sformatf("v%0d_dbus_addr", idx), c_addr, v.e_addr);
      check($sformatf("v%0d_dbus_we", idx), 32'(c_we), 32'(v.st));
      check($sformatf("v%0d_dbus_be", idx), 32'(c_be), 32'(v.e_be));
      check($sformatf("v%0d_req_stable", idx), 32'(stable), 32'd1);
      if (v.st) check($sformatf("v%0d_dbus_wdata", idx), c_wdata, v.e_wdata);
    end
    @(negedge clk);
    check($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'(v.e_wb));
    check($sformatf("v%0d_exc", idx), 32'(exc_misaligned), 32'(v.e_exc));
    if (v.e_wb) begin
      check($sformatf("v%0d_wb_data", idx), wb_data, v.e_wb_data);
      check($sformatf("v%0d_wb_rd", idx), 32'(wb_rd), 32'(v.rd));
      check($sformatf("v%0d_wb_pc", idx), wb_pc, pc);
    end
    if (v.e_exc) begin
      check($sformatf("v%0d_exc_addr", idx), exc_addr, v.addr);
      check($sformatf("v%0d_exc_pc", idx), exc_pc, pc);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //           ld st sz sx addr          data          we rd rdata   rw rsw rdy req e_addr        e_wdata       e_be     wb wb_data       exc
    vecs[0]  = '{0, 0, 0, 0, 32'h00001234, 32'h0,        1, 5, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 32'h00001234, 0};
    vecs[1]  = '{0, 0, 0, 0, 32'h00001234, 32'h0,        1, 0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0};
    vecs[2]  = '{1, 0, 0, 1, 32'h00001003, 32'h0,        1, 7, RD_WORD, 0, 0, 2, 1, 32'h00001000, 32'h0,        4'b1000, 1, 32'hFFFFFF80, 0};
    vecs[3]  = '{1, 0, 1, 0, 32'h00001002, 32'h0,        1, 8, RD_WORD, 0, 0, 2, 1, 32'h00001000, 32'h0,        4'b1100, 1, 32'h000080FF, 0};
    vecs[4]  = '{1, 0, 2, 0, 32'h00001000, 32'h0,        1, 9, RD_WORD, 0, 0, 2, 1, 32'h00001000, 32'h0,        4'b1111, 1, 32'h80FF7F01, 0};
    vecs[5]  = '{0, 1, 1, 0, 32'h00002002, 32'h0000ABCD, 0, 0, 32'h0,   0, 0, 1, 1, 32'h00002000, 32'hABCDABCD, 4'b1100, 0, 32'h0,        0};
    vecs[6]  = '{1, 0, 2, 0, 32'h00003001, 32'h0,        1, 3, RD_WORD, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[7]  = '{1, 0, 3, 0, 32'h00003000, 32'h0,        1, 3, RD_WORD, 0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[8]  = '{1, 0, 2, 0, 32'h00001000, 32'h0,        1,10, RD_WORD, 3, 2, 7, 1, 32'h00001000, 32'h0,        4'b1111, 1, 32'h80FF7F01, 0};
    vecs[9]  = '{0, 1, 0, 0, 32'h00004001, 32'h1234565A, 0, 0, 32'h0,   0, 0, 1, 1, 32'h00004000, 32'h5A5A5A5A, 4'b0010, 0, 32'h0,        0};
    vecs[10] = '{1, 0, 0, 1, 32'h00001001, 32'h0,        1,11, RD_WORD, 0, 0, 2, 1, 32'h00001000, 32'h0,        4'b0010, 1, 32'h0000007F, 0};
    vecs[11] = '{1, 0, 1, 1, 32'h00001002, 32'h0,        1,12, RD_WORD, 0, 0, 2, 1, 32'h00001000, 32'h0,        4'b1100, 1, 32'hFFFF80FF, 0};
    vecs[12] = '{1, 0, 2, 0, 32'h00001000, 32'h0,        1, 0, RD_WORD, 0, 0, 2, 1, 32'h00001000, 32'h0,        4'b1111, 0, 32'h0,        0};
    vecs[13] = '{0, 1, 1, 0, 32'h00002003, 32'h00001111, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        1};
    vecs[14] = '{0, 1, 2, 0, 32'h00006004, 32'hCAFEF00D, 0, 0, 32'h0,   2, 0, 3, 1, 32'h00006004, 32'hCAFEF00D, 4'b1111, 0, 32'h0,        0};

    // Reset with a valid ALU op presented: nothing may be consumed
    dbus_req_ready = 1'b1;
    dbus_rsp_valid = 1'b0;
    dbus_rdata     = JUNK;
    drive_op(vecs[0], 32'h40);
    @(negedge clk);
    check("rst_ready", 32'(ex_if.ready), 32'd0);
    check("rst_req_valid", 32'(dbus_req_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_exc", 32'(exc_misaligned), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_dbus_addr", dbus_addr, 32'd0);
    ex_if.valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU stream: three back-to-back ops, one writeback per cycle
    @(posedge clk); #1;
    drive_op(vecs[0], 32'h80);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) check($sformatf("alu_ready_%0d", i), 32'(ex_if.ready), 32'd1);
      check($sformatf("alu_wb_valid_%0d", i), 32'(wb_valid), (i >= 1 && i <= 3) ? 32'd1 : 32'd0);
      if (i >= 1 && i <= 3) check($sformatf("alu_wb_data_%0d", i), wb_data, 32'h1234);
      @(posedge clk); #1;
      if (i == 2) ex_if.valid = 1'b0;
    end

    // ALU stream with rd = 0: no writebacks at all
    drive_op(vecs[1], 32'h90);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("alu_x0_wb_valid_%0d", i), 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      if (i == 2) ex_if.valid = 1'b0;
    end

    // Table of single instructions
    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset while waiting for a load response
    @(posedge clk); #1;
    dbus_req_ready = 1'b1;
    dbus_rsp_valid = 1'b0;
    drive_op(vecs[4], 32'h200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rsp_wait_ready", 32'(ex_if.ready), 32'd0);
    check("rsp_wait_addr", dbus_addr, 32'h1000);
    #2;
    rst            = 1'b0;
    dbus_rsp_valid = 1'b1;
    dbus_rdata     = RD_WORD;
    #1;
    check("arst_ready", 32'(ex_if.ready), 32'd0);
    check("arst_req_valid", 32'(dbus_req_valid), 32'd0);
    check("arst_dbus_addr", dbus_addr, 32'd0);
    check("arst_dbus_be", 32'(dbus_be), 32'd0);
    check("arst_wb_valid", 32'(wb_valid), 32'd0);
    check("arst_exc", 32'(exc_misaligned), 32'd0);
    ex_if.valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    dbus_rsp_valid = 1'b0;
    dbus_rdata     = JUNK;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("late_rsp_wb_valid_%0d", i), 32'(wb_valid), 32'd0);
      check($sformatf("late_rsp_req_valid_%0d", i), 32'(dbus_req_valid), 32'd0);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rvee_mem.md
# rvee_mem

Memory stage of the rvee pipeline. Consumes completed instructions from the execute stage over `rvee_exec_if.mem_port`, issues loads and stores on a single-outstanding data bus, aligns and extends load data, and delivers one registered writeback per retired instruction to the register file. Misaligned or illegal-size accesses are flagged and never reach the bus.

## Interface
- `XLEN`, 32: datapath width. Only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex`  modport  `rvee_exec_if.mem_port`  execute-stage payload.
  - Inputs: `valid`, `pc`, `rd_we`, `rd`, `result`, `mem_load`, `mem_store`, `mem_data`, `mem_size`, `mem_sext`.
  - Output: `ready`.
  - `result` is the effective address for memory ops.
- `dbus_req_valid`  out  1  bus request valid.
- `dbus_req_ready`  in  1  bus accepts request.
- `dbus_addr`  out  XLEN  word-aligned address (`result & ~3`).
- `dbus_we`  out  1  1 = store.
- `dbus_wdata`  out  XLEN  lane-replicated store data.
- `dbus_be`  out  4  byte enables.
- `dbus_rsp_valid`  in  1  load data valid. Store requests produce no response.
- `dbus_rdata`  in  XLEN  load data word.
- `wb_valid`  out  1  writeback pulse.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  XLEN  writeback value.
- `wb_pc`  out  XLEN  pc of the retired instruction.
- `exc_misaligned`  out  1  one-cycle pulse on a rejected access.
- `exc_pc`  out  XLEN  pc of the rejected access.
- `exc_addr`  out  XLEN  address of the rejected access.

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE, `ex.valid` = 0: do nothing.
- IDLE, non-memory op:
  - `ex.ready` = 1 combinationally.
  - Next cycle: `wb_valid` = `rd_we && rd != 0`, with `wb_data` = `result`.
- IDLE, memory op, legal access:
  - `ex.ready` = 0; latch the payload; go to REQ.
- Legality rules:
  - `mem_size` 0 (byte): always legal.
  - `mem_size` 1 (half): legal when `addr[0]` = 0.
  - `mem_size` 2 (word): legal when `addr[1:0]` = 0.
  - `mem_size` 3: illegal.
- IDLE, memory op, illegal access:
  - `ex.ready` = 1; no bus request.
  - Next cycle: `exc_misaligned` = 1 with `exc_pc` and `exc_addr`; `wb_valid` = 0.
- REQ:
  - `dbus_req_valid` = 1; address, write data and byte enables held stable until `dbus_req_ready`.
  - Store accepted: `ex.ready` = 1 that cycle; go to IDLE.
  - Load accepted: go to RSP.
- RSP:
  - Wait for `dbus_rsp_valid`; on it, `ex.ready` = 1.
  - Next cycle: `wb_valid` = `rd_we && rd != 0`, with the extracted load value.
  - Go to IDLE.
- Store data lanes:
  - byte: `{4{d[7:0]}}`
  - half: `{2{d[15:0]}}`
  - word: `d`
- Byte enables:
  - byte: `4'b0001 << a[1:0]`
  - half: `4'b0011 << a[1:0]`
  - word: `4'b1111`
- Load extraction:
  - `s = rdata >> (8*a[1:0])`.
  - Take 8 or 16 low bits of `s` (word: all 32).
  - Sign-extend when `mem_sext` = 1, otherwise zero-extend.
- `dbus_rsp_valid` outside RSP is ignored.
- At most one bus transaction is outstanding.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `dbus_req_valid`, `wb_valid`, `exc_misaligned`, `ex.ready` = 0.
  - `dbus_addr`, `dbus_wdata`, `dbus_be`, `dbus_we`, `wb_rd`, `wb_data`, `wb_pc`, `exc_pc`, `exc_addr` = 0.
  - A response pending at reset is dropped; the bus is reset with the core.

## Timing
- Non-memory op: retires in the same cycle it is presented; writeback one cycle later. Sustained rate is 1 instruction per clock.
- Load, zero-wait bus (valid at cycle 0):
  - REQ at cycle 1, accepted at cycle 1.
  - Response at cycle 2; `ex.ready` at cycle 2.
  - `wb_valid` at cycle 3.
- Store, zero-wait bus: `ex.ready` at cycle 1; 2 cycles per store.
- Each cycle of `dbus_req_ready` = 0 or missing response adds exactly one cycle.
- `wb_valid` and `exc_misaligned` are registered single-cycle pulses and are never both high.
- `ex.ready` is high for exactly one cycle per instruction and only while `ex.valid` = 1.

## Test plan
- ALU op stream:
  - Stimulus: `rd`=5, `result`=0x1234 on 3 back-to-back ops.
  - Response: 3 `wb_valid` pulses on consecutive cycles, each with `wb_data`=0x1234.
  - Stimulus: same with `rd`=0. Response: no `wb_valid`.
- Loads from `rdata`=0x80FF7F01:
  - Signed byte at addr 0x1003 -> `wb_data`=0xFFFFFF80.
  - Unsigned half at 0x1002 -> 0x000080FF.
  - Word at 0x1000 -> 0x80FF7F01.
  - `dbus_addr`=0x1000 in every case.
- Store half 0xABCD at 0x2002:
  - Response: `dbus_wdata`=0xABCDABCD, `dbus_be`=4'b1100, `dbus_we`=1, no writeback.
- Misaligned word load at 0x3001:
  - Response: no `dbus_req_valid`; `exc_misaligned` pulse with `exc_addr`=0x3001; `ex.ready` one cycle.
  - `mem_size`=3 gives the same response.
- Backpressure:
  - Stimulus: `dbus_req_ready` low for 3 cycles, then response delayed 2 cycles.
  - Response: request fields stable throughout; `ex.ready` only on the response cycle; load completes 5 cycles later than the zero-wait case.
- Reset asserted in RSP:
  - Response: all outputs 0 immediately.
  - A late `dbus_rsp_valid` after release produces no writeback.
